// File: rtl/board_input_ctrl.sv
// Board input controller: synchronises and debounces four push-buttons, generates the
// manual single-step CPU clock and the PC/register display selection.
module board_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CLK_HIGH_CYCLES = 2,
    parameter int REG_COUNT       = 18
) (
    input  logic        FPGAclk_div,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_mode,
    output logic        cpu_clk,
    output logic        display_pc,
    output logic [4:0]  display_reg,
    output logic [15:0] step_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_W = $clog2(CLK_HIGH_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_HIGH_CYCLES - 1);
    localparam logic [4:0]      REG_LAST = 5'(REG_COUNT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Bit order for all per-button vectors: {mode, down, up, step}
    logic [3:0]      btn_raw;
    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      deb_lvl;
    logic [3:0]      deb_lvl_d;
    logic [3:0]      btn_evt;
    logic [DB_W-1:0] deb_cnt [4];

    logic [1:0]      state;
    logic [HC_W-1:0] hc_cnt;

    assign btn_raw = {btn_mode, btn_down, btn_up, btn_step};
    assign btn_evt = deb_lvl & ~deb_lvl_d;

    // Synchroniser and debounce, one lane per button
    always_ff @(posedge FPGAclk_div or posedge reset) begin
        if (reset) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            deb_lvl   <= '0;
            deb_lvl_d <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            deb_lvl_d <= deb_lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DB_LAST) begin
                    deb_lvl[i] <= ~deb_lvl[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Step FSM: events arriving outside IDLE are simply dropped
    always_ff @(posedge FPGAclk_div or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            hc_cnt     <= '0;
            cpu_clk    <= 1'b0;
            step_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hc_cnt <= '0;
                    if (btn_evt[0]) begin
                        state      <= ST_HIGH;
                        cpu_clk    <= 1'b1;
                        step_count <= step_count + 16'd1;
                    end
                end
                ST_HIGH: begin
                    if (hc_cnt == HC_LAST) begin
                        state   <= ST_LOW;
                        cpu_clk <= 1'b0;
                        hc_cnt  <= '0;
                    end else begin
                        hc_cnt <= hc_cnt + HC_W'(1);
                    end
                end
                ST_LOW: begin
                    if (hc_cnt == HC_LAST) begin
                        state  <= ST_IDLE;
                        hc_cnt <= '0;
                    end else begin
                        hc_cnt <= hc_cnt + HC_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    hc_cnt  <= '0;
                    cpu_clk <= 1'b0;
                end
            endcase
        end
    end

    // Register select and display mode
    always_ff @(posedge FPGAclk_div or posedge reset) begin
        if (reset) begin
            display_reg <= '0;
            display_pc  <= 1'b1;
        end else begin
            if (btn_evt[1] && !btn_evt[2]) begin
                display_reg <= (display_reg == REG_LAST) ? 5'd0 : display_reg + 5'd1;
            end else if (btn_evt[2] && !btn_evt[1]) begin
                display_reg <= (display_reg == 5'd0) ? REG_LAST : display_reg - 5'd1;
            end
            if (btn_evt[3]) display_pc <= ~display_pc;
        end
    end

endmodule
